// File: rtl/truth_table_sweeper_if.sv
// Bus bundle for the truth table sweeper:
// start/status, breadboard drive/capture and the row buffer read port.
interface truth_table_sweeper_if #(
  parameter int RES_W = 10
);
  logic             start;
  logic             w;
  logic             x;
  logic             y;
  logic             z;
  logic [RES_W-1:0] r_in;
  logic             busy;
  logic             done;
  logic [15:0]      sig;
  logic [3:0]       rd_addr;
  logic [RES_W-1:0] rd_data;

  modport master (
    output start, r_in, rd_addr,
    input  w, x, y, z, busy, done, sig, rd_data
  );

  modport slave (
    input  start, r_in, rd_addr,
    output w, x, y, z, busy, done, sig, rd_data
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks the breadboard through all 16 input rows, captures each
// result into a row buffer and folds it into a rotating signature.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 3,
  parameter int RES_W         = 10
) (
  input logic clk,
  input logic rst,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [15:0]      r_sig;
  logic [15:0]      w_sig_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_we;
  logic [RES_W-1:0] r_buf [16];

  // State and control registers; reset aborts any sweep at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sig   <= w_sig_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: settle each row, then sample it
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_sig_nxt   = r_sig;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_sig_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LP_LAST) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_we      = 1'b1;
        w_sig_nxt = {r_sig[14:0], r_sig[15]} ^ 16'(bus.r_in);
        if (r_idx == 4'd15) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row buffer: cleared by reset, written only when sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_we) begin
      r_buf[r_idx] <= bus.r_in;
    end
  end

  assign bus.w       = r_idx[3];
  assign bus.x       = r_idx[2];
  assign bus.y       = r_idx[1];
  assign bus.z       = r_idx[0];
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sig     = r_sig;
  assign bus.rd_data = r_buf[bus.rd_addr];

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential harness stage wrapped around the 4-input/10-output combinational breadboard logic.
- Drives the breadboard inputs w,x,y,z through all 16 rows, high bit first (w = index bit 3, z = bit 0).
- Waits a programmable settle time per row, captures the 10-bit result into a 16-entry row buffer, and folds it into a running signature.
- Replaces the hand-written delay-and-print testbench loop with synthesizable hardware; results are read back through a random-access port.

Parameters:
- SETTLE_CYCLES, 3, clock cycles each row's inputs are held before capture. Legal range 1..15.
- RES_W, 10, width of the captured result vector (r0..r9).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- w  output  1  breadboard input, index bit 3
- x  output  1  breadboard input, index bit 2
- y  output  1  breadboard input, index bit 1
- z  output  1  breadboard input, index bit 0
- r_in  input  RES_W  breadboard outputs; bit0 = r0 ... bit9 = r9
- busy  output  1  sweep in progress
- done  output  1  sweep complete, buffer and signature valid
- sig  output  16  running signature
- rd_addr  input  4  row buffer read address
- rd_data  output  RES_W  row buffer contents at rd_addr

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-high (rst).
  - While rst=1: state=IDLE; idx=0, so w=x=y=z=0; cnt=0; busy=0; done=0; sig=0; all 16 buffer entries=0.
  - Asserting rst mid-sweep aborts the sweep immediately; no partial done.
- Registers:
  - idx[3:0] is the row index; {w,x,y,z} are registered and equal idx.
  - cnt[3:0] is the settle counter.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0, done=0. On start=1 at an edge: idx<=0, cnt<=0, sig<=0, busy<=1, go to SETTLE.
- SETTLE: cnt increments each edge. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: buf[idx]<=r_in and sig<={sig[14:0],sig[15]} ^ {6'b0,r_in}. Then:
  - if idx==15: go to DONE, busy<=0, done<=1, idx holds at 15;
  - else: idx<=idx+1, cnt<=0, go to SETTLE.
- Per-row and sweep timing:
  - Each row takes SETTLE_CYCLES+1 edges.
  - A full sweep takes 16*(SETTLE_CYCLES+1) edges from the start edge to done=1 (64 edges at default).
- DONE:
  - done stays 1 and sig, buffer and {w,x,y,z}=4'b1111 hold.
  - start=1 restarts exactly as from IDLE, with done<=0 on that edge.
- start while busy (SETTLE/SAMPLE) is ignored and has no effect on idx, cnt or sig.
- No wrap-around: idx never advances past 15.
- The buffer is written only in SAMPLE.
- Read port:
  - rd_data=buf[rd_addr], combinational, available at all times.
  - During a sweep, unwritten rows return the previous sweep's values, or 0 after reset.
- sig is 16 bits with rotate-left-by-1 and XOR; r_in is zero-extended to 16 bits.

Test Plan:
- Functional sweep: SETTLE_CYCLES=3, r_in driven from r0=(w|y)&(z|x), r1=(~w&z&x)|(z&y)|(w&x), r2..r9=0; pulse start.
  -> rd_data=10'h000 at addr 0, 10'h002 at addr 5, 10'h003 at addr 15.
  -> busy=1 one edge after start; done=1 exactly 64 edges after start edge.
- Signature: hold r_in=10'h001 constant, run full sweep -> sig=16'hFFFF; after row n, sig=2^n-1.
- Settle timing: SETTLE_CYCLES=1 -> {w,x,y,z} changes every 2 edges; done=1 after 32 edges.
- Start ignored while busy: pulse start again at edge 10 of a sweep -> idx sequence unchanged, done still at edge 64.
- Reset mid-sweep: assert rst at edge 20 -> busy=0, done=0, sig=0, {w,x,y,z}=0, rd_data=0 for all 16 addresses. A new start then produces the same results as the functional-sweep scenario.
- Restart from DONE: start=1 in DONE -> done=0 on that edge, sig cleared, second sweep reproduces identical buffer and sig.
